// File: rtl/calendar_date_counter.sv
// rtl/calendar_date_counter.sv - day/month/year counter with Gregorian leap years and button set mode
// Optional weekday counter enabled by defining CALENDAR_DAY_OF_WEEK_EN.
module calendar_date_counter #(
   parameter int YEAR_MIN   = 2000,
   parameter int YEAR_MAX   = 2099,
   parameter int RESET_YEAR = 2024
`ifdef CALENDAR_DAY_OF_WEEK_EN
   ,parameter int RESET_DOW = 0
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        day_tick,
   input  logic        set_mode,
   input  logic [1:0]  field_sel,
   input  logic        inc_pulse,
   output logic [4:0]  day,
   output logic [3:0]  month,
   output logic [13:0] year,
   output logic        leap_year,
   output logic        date_valid
`ifdef CALENDAR_DAY_OF_WEEK_EN
   ,output logic [2:0] day_of_week
`endif
);

   localparam logic [13:0] YMIN   = 14'(YEAR_MIN);
   localparam logic [13:0] YMAX   = 14'(YEAR_MAX);
   localparam logic [13:0] YRESET = 14'(RESET_YEAR);

   typedef enum logic {ST_RUN, ST_SET} state_t;

   state_t      state_q, state_d;
   logic [4:0]  day_q, day_d;
   logic [3:0]  month_q, month_d;
   logic [13:0] year_q, year_d;
   logic        date_valid_q, date_valid_d;
   logic        in_set;
   logic [4:0]  cur_len, new_len;
   logic [3:0]  month_inc;
   logic [13:0] year_inc;
`ifdef CALENDAR_DAY_OF_WEEK_EN
   logic [2:0]  dow_q, dow_d, dow_inc;
`endif

   function automatic logic is_leap(input logic [13:0] y);
      return (y % 14'd4 == 14'd0) && ((y % 14'd100 != 14'd0) || (y % 14'd400 == 14'd0));
   endfunction

   function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
      case (m)
         4'd2:                      return leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
         default:                   return 5'd31;
      endcase
   endfunction

   assign leap_year = is_leap(year_q);

   always_comb begin
      state_d      = set_mode ? ST_SET : ST_RUN;
      day_d        = day_q;
      month_d      = month_q;
      year_d       = year_q;
      date_valid_d = date_valid_q;
`ifdef CALENDAR_DAY_OF_WEEK_EN
      dow_d        = dow_q;
      dow_inc      = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
`endif
      // On the edge where the state register flips, the incoming state governs
      in_set    = (state_q != state_d) ? (state_d == ST_SET) : (state_q == ST_SET);
      cur_len   = month_len(month_q, leap_year);
      month_inc = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
      year_inc  = (year_q == YMAX) ? YMIN : year_q + 14'd1;

      if (!in_set) begin
         if (day_tick) begin
            date_valid_d = 1'b1;
`ifdef CALENDAR_DAY_OF_WEEK_EN
            dow_d = dow_inc;
`endif
            if (day_q < cur_len) begin
               day_d = day_q + 5'd1;
            end else begin
               day_d   = 5'd1;
               month_d = month_inc;
               if (month_q == 4'd12) year_d = year_inc;
            end
         end
      end else if (inc_pulse) begin
         date_valid_d = 1'b1;
         case (field_sel)
            2'd0:    day_d   = (day_q >= cur_len) ? 5'd1 : day_q + 5'd1;
            2'd1:    month_d = month_inc;
            2'd2:    year_d  = year_inc;
            default: begin
`ifdef CALENDAR_DAY_OF_WEEK_EN
               dow_d = dow_inc;
`endif
            end
         endcase
      end

      // Clamp in the same cycle so a month/year edit never exposes an illegal date
      new_len = month_len(month_d, is_leap(year_d));
      if (day_d > new_len) day_d = new_len;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_RUN;
         day_q        <= 5'd1;
         month_q      <= 4'd1;
         year_q       <= YRESET;
         date_valid_q <= 1'b0;
`ifdef CALENDAR_DAY_OF_WEEK_EN
         dow_q        <= 3'(RESET_DOW);
`endif
      end else begin
         state_q      <= state_d;
         day_q        <= day_d;
         month_q      <= month_d;
         year_q       <= year_d;
         date_valid_q <= date_valid_d;
`ifdef CALENDAR_DAY_OF_WEEK_EN
         dow_q        <= dow_d;
`endif
      end
   end

   assign day        = day_q;
   assign month      = month_q;
   assign year       = year_q;
   assign date_valid = date_valid_q;
`ifdef CALENDAR_DAY_OF_WEEK_EN
   assign day_of_week = dow_q;
`endif

endmodule

// File: tb/tb_calendar_date_counter.sv
// tb/tb_calendar_date_counter.sv - directed bench with calendar reference model for calendar_date_counter
module tb_calendar_date_counter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        day_tick = 1'b0;
   logic        set_mode = 1'b0;
   logic [1:0]  field_sel = 2'd0;
   logic        inc_pulse = 1'b0;
   logic [4:0]  day;
   logic [3:0]  month;
   logic [13:0] year;
   logic        leap_year;
   logic        date_valid;
`ifdef CALENDAR_DAY_OF_WEEK_EN
   logic [2:0]  day_of_week;
`endif

   int vectors = 0;
   int miscompares = 0;

   int m_day, m_month, m_year, m_dow;
   bit m_valid;
   bit model_live = 1'b0;

   always #5 clk = ~clk;

   calendar_date_counter dut (
      .clk        (clk),
      .reset      (reset),
      .day_tick   (day_tick),
      .set_mode   (set_mode),
      .field_sel  (field_sel),
      .inc_pulse  (inc_pulse),
      .day        (day),
      .month      (month),
      .year       (year),
      .leap_year  (leap_year),
      .date_valid (date_valid)
`ifdef CALENDAR_DAY_OF_WEEK_EN
      ,.day_of_week(day_of_week)
`endif
   );

   function automatic bit mleap(int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   function automatic int mlen(int m, int y);
      int tbl [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      return (m == 2 && mleap(y)) ? 29 : tbl[m-1];
   endfunction

   function automatic int next_year(int y);
      return (y == 2099) ? 2000 : y + 1;
   endfunction

   // Reference calendar: inputs are sampled on the same edge as the DUT
   always @(posedge clk) begin
      if (reset) begin
         m_day = 1; m_month = 1; m_year = 2024; m_valid = 0; m_dow = 0;
         model_live = 1'b1;
      end else if (set_mode) begin
         if (inc_pulse) begin
            m_valid = 1;
            case (field_sel)
               2'd0: m_day = (m_day % mlen(m_month, m_year)) + 1;
               2'd1: m_month = (m_month % 12) + 1;
               2'd2: m_year = next_year(m_year);
               default: begin
`ifdef CALENDAR_DAY_OF_WEEK_EN
                  m_dow = (m_dow + 1) % 7;
`endif
               end
            endcase
            if (m_day > mlen(m_month, m_year)) m_day = mlen(m_month, m_year);
         end
      end else if (day_tick) begin
         m_valid = 1;
         m_dow = (m_dow + 1) % 7;
         m_day = m_day + 1;
         if (m_day > mlen(m_month, m_year)) begin
            m_day = 1;
            m_month = m_month + 1;
            if (m_month > 12) begin
               m_month = 1;
               m_year = next_year(m_year);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_live) begin
         chk("model_day", day, m_day);
         chk("model_month", month, m_month);
         chk("model_year", year, m_year);
         chk("model_leap", leap_year, mleap(m_year));
         chk("model_valid", date_valid, m_valid);
`ifdef CALENDAR_DAY_OF_WEEK_EN
         chk("model_dow", day_of_week, m_dow);
`endif
      end
   end

   task automatic lit(input string tag, input int d, input int m, input int y, input int lp, input int v);
      chk({tag, "_day"}, day, d);
      chk({tag, "_month"}, month, m);
      chk({tag, "_year"}, year, y);
      chk({tag, "_leap"}, leap_year, lp);
      chk({tag, "_valid"}, date_valid, v);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [1:0] fs);
      field_sel = fs;
      inc_pulse = 1'b1;
      cyc();
      inc_pulse = 1'b0;
   endtask

   task automatic tick();
      day_tick = 1'b1;
      cyc();
      day_tick = 1'b0;
   endtask

   // Leaves the design in SET with the requested date loaded
   task automatic set_date(input int d, input int m, input int y);
      int n;
      set_mode = 1'b1;
      cyc();
      n = 0;
      while (m_year != y && n < 300) begin pulse(2'd2); n++; end
      while (m_month != m && n < 300) begin pulse(2'd1); n++; end
      while (m_day != d && n < 300) begin pulse(2'd0); n++; end
      chk("set_date_budget", (n < 300) ? 1 : 0, 1);
   endtask

   initial begin
      cyc();
      cyc();
      reset = 1'b0;
      lit("reset", 1, 1, 2024, 1, 0);
      cyc();
      lit("reset_hold", 1, 1, 2024, 1, 0);

`ifdef CALENDAR_DAY_OF_WEEK_EN
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("dow_seq", day_of_week, (i + 1) % 7);
      end
      set_mode = 1'b1;
      cyc();
      pulse(2'd3);
      chk("dow_set", day_of_week, 1);
      set_mode = 1'b0;
      cyc();
`else
      set_mode = 1'b1;
      pulse(2'd3);
      lit("fsel3_noop", 1, 1, 2024, 1, 1);
      set_mode = 1'b0;
      pulse(2'd0);
      lit("run_ignores_inc", 1, 1, 2024, 1, 1);
`endif

      set_date(28, 2, 2023);
      set_mode = 1'b0;
      tick();
      lit("feb_nonleap", 1, 3, 2023, 0, 1);

      set_date(28, 2, 2024);
      set_mode = 1'b0;
      tick();
      lit("feb_leap_29", 29, 2, 2024, 1, 1);
      tick();
      lit("feb_leap_mar", 1, 3, 2024, 1, 1);

      set_date(31, 12, 2099);
      set_mode = 1'b0;
      tick();
      lit("year_wrap", 1, 1, 2000, 1, 1);

      set_date(31, 1, 2023);
      lit("preset_jan31", 31, 1, 2023, 0, 1);
      pulse(2'd1);
      lit("clamp_month", 28, 2, 2023, 0, 1);
      pulse(2'd2);
      lit("year_edit", 28, 2, 2024, 1, 1);
      pulse(2'd0);
      lit("set_day_29", 29, 2, 2024, 1, 1);
      pulse(2'd0);
      lit("set_day_wrap", 1, 2, 2024, 1, 1);

      set_date(5, 6, 2024);
      day_tick = 1'b1;
      field_sel = 2'd0;
      inc_pulse = 1'b1;
      cyc();
      day_tick = 1'b0;
      inc_pulse = 1'b0;
      lit("tick_dropped_in_set", 6, 6, 2024, 1, 1);
      cyc();
      lit("tick_not_queued", 6, 6, 2024, 1, 1);

      reset = 1'b1;
      cyc();
      reset = 1'b0;
      set_mode = 1'b0;
      lit("reset_in_set", 1, 1, 2024, 1, 0);
      tick();
      lit("run_after_reset", 2, 1, 2024, 1, 1);

      // Long run crossing several month and year boundaries, with idle gaps
      for (int i = 0; i < 900; i++) begin
         day_tick = (i % 3 != 2);
         cyc();
      end
      day_tick = 1'b0;

      // Mode toggling on the same edge as the pulses
      for (int i = 0; i < 40; i++) begin
         set_mode  = i[2];
         field_sel = 2'(i % 3);
         inc_pulse = i[0];
         day_tick  = ~i[0];
         cyc();
      end
      set_mode = 1'b0;
      inc_pulse = 1'b0;
      day_tick = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
- Date-keeping stage that sits directly upstream of the month/leap-year check and the 7-segment decode path.
- Consumes a one-cycle day_tick from the time-of-day counter at midnight.
- Advances day/month/year with Gregorian leap-year handling.
- Provides a button-driven set mode for manual date entry.

Parameters:
- YEAR_MIN, 2000, lowest year value; wrap target.
- YEAR_MAX, 2099, highest year value; wrap source.
- RESET_YEAR, 2024, year loaded on reset; must lie within YEAR_MIN..YEAR_MAX.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- day_tick  input  1  one-cycle pulse; advance date by one day.
- set_mode  input  1  level; 1 = SET state, 0 = RUN state.
- field_sel  input  2  field to edit in SET: 0 = day, 1 = month, 2 = year, 3 = weekday (only with macro).
- inc_pulse  input  1  one-cycle pulse from the debounced button; increments the selected field.
- day  output  5  day of month, 1..31.
- month  output  4  month, 1..12.
- year  output  14  year, YEAR_MIN..YEAR_MAX.
- leap_year  output  1  1 when the current year is a leap year.
- date_valid  output  1  1 once the date has been set or advanced at least once since reset.

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs):
  - day = 1, month = 1, year = RESET_YEAR, date_valid = 0, state = RUN.
  - A reset mid-edit discards the edit.
- leap_year is combinational from the year register:
  - 1 if year mod 4 == 0 and (year mod 100 != 0 or year mod 400 == 0), else 0.
- Month length:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - 29 for month 2 when leap_year, else 28.
- State follows set_mode with a one-cycle registered transition. State changes on the clock edge after set_mode changes.
- RUN state:
  - On day_tick, if day < month length: day++.
  - Else, if month < 12: day = 1, month++.
  - Else: day = 1, month = 1, year++.
  - If year == YEAR_MAX on that roll-over, year = YEAR_MIN.
  - Outputs update on the edge that samples day_tick (latency 1).
  - date_valid is set to 1 on the first advance.
  - inc_pulse is ignored in RUN.
- SET state:
  - day_tick is dropped; it is not queued.
  - On inc_pulse with field_sel = 0: day++; day wraps to 1 after the month length.
  - On inc_pulse with field_sel = 1: month++; month wraps 12 -> 1.
  - On inc_pulse with field_sel = 2: year++; year wraps YEAR_MAX -> YEAR_MIN.
  - Clamp: after a month or year edit, if day exceeds the new month length, day = new month length. The clamp is applied in the same cycle as the edit, so outputs are never an illegal date.
  - Each inc_pulse sets date_valid = 1.
- Simultaneous day_tick and inc_pulse: only the one legal in the current state acts.
- In the cycle the state register changes, the new state's rules apply to inputs sampled in that cycle.
- All outputs are registered except leap_year.

Optional Feature:
- Macro: CALENDAR_DAY_OF_WEEK_EN.
- When defined:
  - Adds output day_of_week (3 bits, 0 = Monday .. 6 = Sunday) and parameter RESET_DOW (default 0).
  - day_of_week resets to RESET_DOW.
  - In RUN it increments mod 7 on every day_tick advance, in the same cycle as day.
  - In SET, inc_pulse with field_sel = 3 increments it mod 7.
- When not defined:
  - The day_of_week port and its logic are absent.
  - field_sel = 3 with inc_pulse has no effect.

Test Plan:
- Reset held 2 cycles, then released -> day = 1, month = 1, year = 2024, leap_year = 1, date_valid = 0.
- Preset 28/02/2023 via SET, then RUN with one day_tick -> 01/03/2023. Preset 28/02/2024, one day_tick -> 29/02/2024; a second day_tick -> 01/03/2024.
- Preset 31/12/2099, one day_tick -> 01/01/2000. Also check leap_year: year 2000 -> 1, year 2023 -> 0.
- SET with 31/01/2023, field_sel = 1, one inc_pulse -> 28/02/2023 in the same cycle. Then field_sel = 2, one inc_pulse -> 28/02/2024 (no clamp needed).
- SET with day_tick and inc_pulse (field_sel = 0) both asserted on 05/06/2024 -> 06/06/2024 and the day_tick is lost. Then assert reset while in SET -> 01/01/2024, state RUN.
- With CALENDAR_DAY_OF_WEEK_EN and RESET_DOW = 0: 7 day_ticks -> day_of_week sequence 1,2,3,4,5,6,0. In SET, field_sel = 3 with one inc_pulse -> 1.
